// File: rtl/dsp_pkg.sv
// Shared constants and fit-range helpers for the DSP slice.
// Wide signed arithmetic keeps range checks independent of operand width.
package dsp_pkg;

  localparam int MREG_MAX = 4;
  localparam int WIDE_W   = 128;

  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic wide_t fit_smax(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t fit_smin(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  function automatic wide_t fit_umax(input int w);
    return (wide_t'(1) <<< w) - wide_t'(1);
  endfunction

  function automatic wide_t fit_umin(input int w);
    return wide_t'(w - w);
  endfunction

endpackage

// File: rtl/mult_pipe_stage_if.sv
// Sample bus of the multiplier stage: operands in, fitted product out.
// master drives operands, slave is the multiplier.
interface mult_pipe_stage_if #(
  parameter int A_WIDTH   = 25,
  parameter int B_WIDTH   = 18,
  parameter int OUT_WIDTH = 43
);

  logic                 IN_VALID;
  logic                 SIGNED_MODE;
  logic [A_WIDTH-1:0]   A_D;
  logic [B_WIDTH-1:0]   B;
  logic                 OUT_VALID;
  logic [OUT_WIDTH-1:0] MULT_OUT;
  logic                 OVF;

  modport master (
    output IN_VALID, SIGNED_MODE, A_D, B,
    input  OUT_VALID, MULT_OUT, OVF
  );

  modport slave (
    input  IN_VALID, SIGNED_MODE, A_D, B,
    output OUT_VALID, MULT_OUT, OVF
  );

endinterface

// File: rtl/mult_postproc.sv
// Combinational scale (round half up, shift) and fit (saturate or wrap)
// of a P-bit product, flagging any value outside the output range.
module mult_postproc
  import dsp_pkg::*;
#(
  parameter int P         = 45,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 0,
  parameter int SAT       = 0,
  parameter int OUT_WIDTH = 43
) (
  input  logic                 i_signed,
  input  logic [P-1:0]         i_prod,
  output logic [OUT_WIDTH-1:0] o_out,
  output logic                 o_ovf
);

  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [P-1:0] RND_K =
    (ROUND != 0 && SHIFT > 0) ? (P'(1) << RS) : '0;

  localparam wide_t S_MAX = fit_smax(OUT_WIDTH);
  localparam wide_t S_MIN = fit_smin(OUT_WIDTH);
  localparam wide_t U_MAX = fit_umax(OUT_WIDTH);
  localparam wide_t U_MIN = fit_umin(OUT_WIDTH);

  logic [P-1:0] w_rnd;
  logic [P-1:0] w_sh;
  wide_t        w_ext;
  logic         w_hi;
  logic         w_lo;

  // rounding carry stays inside P bits, which never overflow for legal widths
  assign w_rnd = i_prod + RND_K;

  always_comb begin
    w_sh  = w_rnd >> SHIFT;
    w_ext = {{(WIDE_W-P){1'b0}}, w_sh};
    w_hi  = 1'b0;
    w_lo  = 1'b0;
    if (i_signed) begin
      w_sh  = $signed(w_rnd) >>> SHIFT;
      w_ext = {{(WIDE_W-P){w_sh[P-1]}}, w_sh};
      w_hi  = w_ext > S_MAX;
      w_lo  = w_ext < S_MIN;
    end else begin
      w_hi  = w_ext > U_MAX;
      w_lo  = w_ext < U_MIN;
    end
  end

  always_comb begin
    o_ovf = w_hi | w_lo;
    o_out = w_sh[OUT_WIDTH-1:0];
    if (SAT != 0 && w_hi) begin
      o_out = i_signed ? S_MAX[OUT_WIDTH-1:0] : U_MAX[OUT_WIDTH-1:0];
    end else if (SAT != 0 && w_lo) begin
      o_out = i_signed ? S_MIN[OUT_WIDTH-1:0] : U_MIN[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_pipe_stage.sv
// Pipelined multiplier output stage: product, optional pre-register,
// post-processing and a valid-tracked register chain of depth MREG.
module mult_pipe_stage
  import dsp_pkg::*;
#(
  parameter int A_WIDTH   = 25,
  parameter int B_WIDTH   = 18,
  parameter int MREG      = 1,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 0,
  parameter int SAT       = 0,
  parameter int OUT_WIDTH = 43
) (
  input  logic CLK,
  input  logic RSTM_N,
  input  logic SRSTM,
  input  logic CEM,
  mult_pipe_stage_if.slave bus
);

  localparam int P  = A_WIDTH + B_WIDTH + 2;
  localparam int ND = (MREG >= 2) ? MREG - 1 : MREG;

  if (MREG < 0 || MREG > MREG_MAX) begin : g_bad_mreg
    $error("mult_pipe_stage: MREG out of range");
  end

  logic [P-1:0]         w_a_ext;
  logic [P-1:0]         w_b_ext;
  logic [P-1:0]         w_prod;
  logic [P-1:0]         w_pp_prod;
  logic                 w_pp_sgn;
  logic                 w_pp_vld;
  logic [OUT_WIDTH-1:0] w_pp_out;
  logic                 w_pp_ovf;

  assign w_a_ext = {{(P-A_WIDTH){bus.SIGNED_MODE & bus.A_D[A_WIDTH-1]}},
                    bus.A_D};
  assign w_b_ext = {{(P-B_WIDTH){bus.SIGNED_MODE & bus.B[B_WIDTH-1]}},
                    bus.B};
  // low P bits of the extended product are exact in both modes
  assign w_prod  = w_a_ext * w_b_ext;

  if (MREG >= 2) begin : g_s1
    logic [P-1:0] r_prod;
    logic         r_sgn;
    logic         r_vld;

    always_ff @(posedge CLK or negedge RSTM_N) begin
      if (!RSTM_N) begin
        r_prod <= '0;
        r_sgn  <= 1'b0;
        r_vld  <= 1'b0;
      end else if (SRSTM) begin
        r_prod <= '0;
        r_sgn  <= 1'b0;
        r_vld  <= 1'b0;
      end else if (CEM) begin
        r_vld <= bus.IN_VALID;
        if (bus.IN_VALID) begin
          r_prod <= w_prod;
          r_sgn  <= bus.SIGNED_MODE;
        end
      end
    end

    assign w_pp_prod = r_prod;
    assign w_pp_sgn  = r_sgn;
    assign w_pp_vld  = r_vld;
  end else begin : g_s0
    assign w_pp_prod = w_prod;
    assign w_pp_sgn  = bus.SIGNED_MODE;
    assign w_pp_vld  = bus.IN_VALID;
  end

  mult_postproc #(
    .P         (P),
    .SHIFT     (SHIFT),
    .ROUND     (ROUND),
    .SAT       (SAT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_pp (
    .i_signed (w_pp_sgn),
    .i_prod   (w_pp_prod),
    .o_out    (w_pp_out),
    .o_ovf    (w_pp_ovf)
  );

  if (ND == 0) begin : g_comb
    assign bus.OUT_VALID = w_pp_vld;
    assign bus.MULT_OUT  = w_pp_out;
    assign bus.OVF       = w_pp_ovf;
  end else begin : g_reg
    logic [OUT_WIDTH-1:0] r_out [ND];
    logic [ND-1:0]        r_ovf;
    logic [ND-1:0]        r_vld;

    // valid always advances; data only moves behind a valid bit
    always_ff @(posedge CLK or negedge RSTM_N) begin
      if (!RSTM_N) begin
        r_vld <= '0;
        r_ovf <= '0;
        for (int i = 0; i < ND; i++) r_out[i] <= '0;
      end else if (SRSTM) begin
        r_vld <= '0;
        r_ovf <= '0;
        for (int i = 0; i < ND; i++) r_out[i] <= '0;
      end else if (CEM) begin
        r_vld[0] <= w_pp_vld;
        if (w_pp_vld) begin
          r_out[0] <= w_pp_out;
          r_ovf[0] <= w_pp_ovf;
        end
        for (int i = 1; i < ND; i++) begin
          r_vld[i] <= r_vld[i-1];
          if (r_vld[i-1]) begin
            r_out[i] <= r_out[i-1];
            r_ovf[i] <= r_ovf[i-1];
          end
        end
      end
    end

    assign bus.OUT_VALID = r_vld[ND-1];
    assign bus.MULT_OUT  = r_out[ND-1];
    assign bus.OVF       = r_ovf[ND-1];
  end

endmodule

// File: tb/tb_mult_pipe_stage.sv
// Bench for mult_pipe_stage: vector table, corner sequences and a
// randomized run against an integer-arithmetic reference model.
module tb_mult_pipe_stage;

  logic CLK;
  logic RSTM_N;
  logic SRSTM;
  logic CEM;

  int n_cmp = 0;
  int n_err = 0;

  mult_pipe_stage_if #(.A_WIDTH(25), .B_WIDTH(18), .OUT_WIDTH(43)) if0 ();
  mult_pipe_stage_if #(.A_WIDTH(25), .B_WIDTH(18), .OUT_WIDTH(16)) if1 ();
  mult_pipe_stage_if #(.A_WIDTH(25), .B_WIDTH(18), .OUT_WIDTH(16)) if2 ();
  mult_pipe_stage_if #(.A_WIDTH(25), .B_WIDTH(18), .OUT_WIDTH(43)) if3 ();

  mult_pipe_stage u0 (
    .CLK(CLK), .RSTM_N(RSTM_N), .SRSTM(SRSTM), .CEM(CEM), .bus(if0)
  );

  mult_pipe_stage #(
    .MREG(1), .SHIFT(4), .ROUND(1), .SAT(1), .OUT_WIDTH(16)
  ) u1 (
    .CLK(CLK), .RSTM_N(RSTM_N), .SRSTM(SRSTM), .CEM(CEM), .bus(if1)
  );

  mult_pipe_stage #(
    .MREG(1), .SHIFT(4), .ROUND(1), .SAT(0), .OUT_WIDTH(16)
  ) u2 (
    .CLK(CLK), .RSTM_N(RSTM_N), .SRSTM(SRSTM), .CEM(CEM), .bus(if2)
  );

  mult_pipe_stage #(.MREG(3)) u3 (
    .CLK(CLK), .RSTM_N(RSTM_N), .SRSTM(SRSTM), .CEM(CEM), .bus(if3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit s,
                       input logic [24:0] a, input logic [17:0] b);
    if0.IN_VALID = v; if0.SIGNED_MODE = s; if0.A_D = a; if0.B = b;
    if1.IN_VALID = v; if1.SIGNED_MODE = s; if1.A_D = a; if1.B = b;
    if2.IN_VALID = v; if2.SIGNED_MODE = s; if2.A_D = a; if2.B = b;
    if3.IN_VALID = v; if3.SIGNED_MODE = s; if3.A_D = a; if3.B = b;
  endtask

  task automatic rd(input int d, output bit v, output logic [63:0] o,
                    output bit ov);
    v = 1'b0; o = '0; ov = 1'b0;
    case (d)
      0: begin v = if0.OUT_VALID; o = 64'(if0.MULT_OUT); ov = if0.OVF; end
      1: begin v = if1.OUT_VALID; o = 64'(if1.MULT_OUT); ov = if1.OVF; end
      2: begin v = if2.OUT_VALID; o = 64'(if2.MULT_OUT); ov = if2.OVF; end
      default: begin
        v = if3.OUT_VALID; o = 64'(if3.MULT_OUT); ov = if3.OVF;
      end
    endcase
  endtask

  // reference: exact integer product, scale, then range-fit
  function automatic void model(input bit sgn, input logic [24:0] a,
      input logic [17:0] b, input int sh, input int rnd, input int sat,
      input int ow, output logic [63:0] o, output bit ov);
    longint av, bv, p, lo, hi;
    if (sgn) begin
      av = longint'($signed(a));
      bv = longint'($signed(b));
      lo = -(longint'(1) << (ow - 1));
      hi = (longint'(1) << (ow - 1)) - 1;
    end else begin
      av = longint'(a);
      bv = longint'(b);
      lo = 0;
      hi = (longint'(1) << ow) - 1;
    end
    p = av * bv;
    if (rnd != 0 && sh > 0) p = p + (longint'(1) << (sh - 1));
    p = p >>> sh;
    ov = (p < lo) || (p > hi);
    if (sat != 0 && p < lo) p = lo;
    if (sat != 0 && p > hi) p = hi;
    o = 64'(p) & ((64'd1 << ow) - 64'd1);
  endfunction

  typedef struct {
    string       nm;
    int          d;
    bit          s;
    logic [24:0] a;
    logic [17:0] b;
    logic [63:0] eo;
    bit          ev;
  } vec_t;

  typedef struct {
    int          k;
    logic [63:0] o0, o1, o2;
    bit          v0, v1, v2;
  } rec_t;

  function automatic logic [24:0] rand_a();
    logic [24:0] r;
    case ($urandom % 4)
      0: r = 25'($urandom);
      1: r = 25'($urandom_range(0, 127)) - 25'd64;
      2: case ($urandom % 4)
           0: r = 25'h0000000;
           1: r = 25'h1FFFFFF;
           2: r = 25'h1000000;
           default: r = 25'h0FFFFFF;
         endcase
      default: r = 25'($urandom_range(0, 4095));
    endcase
    return r;
  endfunction

  function automatic logic [17:0] rand_b();
    logic [17:0] r;
    case ($urandom % 4)
      0: r = 18'($urandom);
      1: r = 18'($urandom_range(0, 127)) - 18'd64;
      2: case ($urandom % 4)
           0: r = 18'h00000;
           1: r = 18'h3FFFF;
           2: r = 18'h20000;
           default: r = 18'h1FFFF;
         endcase
      default: r = 18'($urandom_range(0, 1023));
    endcase
    return r;
  endfunction

  vec_t        vt [10];
  rec_t        recs [$];
  bit          v;
  bit          ov;
  logic [63:0] o;

  initial begin
    vt[0] = '{"m3x5", 0, 1'b1, 25'h1FFFFFD, 18'd5, 64'h7FFFFFFFFF1, 1'b0};
    vt[1] = '{"umax", 0, 1'b0, 25'h1FFFFFF, 18'h3FFFF, 64'h7FFFDFC0001, 1'b0};
    vt[2] = '{"smax", 0, 1'b1, 25'h1FFFFFF, 18'h3FFFF, 64'd1, 1'b0};
    vt[3] = '{"sminxmin", 0, 1'b1, 25'h1000000, 18'h20000,
              64'h20000000000, 1'b0};
    vt[4] = '{"rnd24", 1, 1'b1, 25'd24, 18'd1, 64'h0002, 1'b0};
    vt[5] = '{"rndm24", 1, 1'b1, 25'h1FFFFE8, 18'd1, 64'hFFFF, 1'b0};
    vt[6] = '{"satpos", 1, 1'b1, 25'd4096, 18'd1024, 64'h7FFF, 1'b1};
    vt[7] = '{"satuns", 1, 1'b0, 25'd4096, 18'd1024, 64'hFFFF, 1'b1};
    vt[8] = '{"wrap", 2, 1'b1, 25'd4096, 18'd1024, 64'h0000, 1'b1};
    vt[9] = '{"edge32767", 1, 1'b1, 25'h7FFF0, 18'd1, 64'h7FFF, 1'b0};

    RSTM_N = 1'b0;
    SRSTM  = 1'b0;
    CEM    = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge CLK);
    for (int d = 0; d < 4; d++) begin
      rd(d, v, o, ov);
      chk($sformatf("rst_vld%0d", d), 64'(v), 64'd0);
      chk($sformatf("rst_out%0d", d), o, 64'd0);
    end
    RSTM_N = 1'b1;
    @(negedge CLK);

    foreach (vt[i]) begin
      drive(1'b1, vt[i].s, vt[i].a, vt[i].b);
      @(posedge CLK);
      @(negedge CLK);
      drive(1'b0, 1'b0, '0, '0);
      rd(vt[i].d, v, o, ov);
      chk({vt[i].nm, "_vld"}, 64'(v), 64'd1);
      chk({vt[i].nm, "_out"}, o, vt[i].eo);
      chk({vt[i].nm, "_ovf"}, 64'(ov), 64'(vt[i].ev));
    end
    repeat (4) @(negedge CLK);

    // MREG=3 with two frozen cycles right after acceptance
    drive(1'b1, 1'b1, 25'd7, 18'd6);
    @(posedge CLK);
    @(negedge CLK);
    drive(1'b0, 1'b0, '0, '0);
    CEM = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      if (c == 4) CEM = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("cem_vld_e%0d", c), 64'(if3.OUT_VALID),
          (c == 5) ? 64'd1 : 64'd0);
    end
    chk("cem_out", 64'(if3.MULT_OUT), 64'd42);
    CEM = 1'b0;
    repeat (2) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("cem_hold_vld", 64'(if3.OUT_VALID), 64'd1);
      chk("cem_hold_out", 64'(if3.MULT_OUT), 64'd42);
    end
    CEM = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("no_dup_vld", 64'(if3.OUT_VALID), 64'd0);
    chk("bubble_hold", 64'(if3.MULT_OUT), 64'd42);

    // asynchronous reset with samples in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 25'(100 + i), 18'd3);
      @(posedge CLK);
      @(negedge CLK);
    end
    chk("pre_arst_out", 64'(if3.MULT_OUT), 64'd300);
    #2 RSTM_N = 1'b0;
    #1;
    chk("arst_vld", 64'(if3.OUT_VALID), 64'd0);
    chk("arst_out", 64'(if3.MULT_OUT), 64'd0);
    chk("arst_ovf", 64'(if3.OVF), 64'd0);
    chk("arst_vld0", 64'(if0.OUT_VALID), 64'd0);
    @(negedge CLK);
    RSTM_N = 1'b1;
    drive(1'b1, 1'b1, 25'd9, 18'd9);
    for (int c = 1; c <= 3; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      drive(1'b0, 1'b0, '0, '0);
      chk($sformatf("post_arst_vld%0d", c), 64'(if3.OUT_VALID),
          (c == 3) ? 64'd1 : 64'd0);
    end
    chk("post_arst_out", 64'(if3.MULT_OUT), 64'd81);

    // synchronous flush while frozen, with a same-cycle sample
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 25'(20 + i), 18'd2);
      @(posedge CLK);
      @(negedge CLK);
    end
    chk("pre_srst_out", 64'(if3.MULT_OUT), 64'd40);
    CEM   = 1'b0;
    SRSTM = 1'b1;
    drive(1'b1, 1'b1, 25'd5, 18'd5);
    @(posedge CLK);
    @(negedge CLK);
    chk("srst_vld", 64'(if3.OUT_VALID), 64'd0);
    chk("srst_out", 64'(if3.MULT_OUT), 64'd0);
    chk("srst_ovf", 64'(if3.OVF), 64'd0);
    chk("srst_vld0", 64'(if0.OUT_VALID), 64'd0);
    SRSTM = 1'b0;
    CEM   = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    repeat (4) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("srst_drained", 64'(if3.OUT_VALID), 64'd0);
    end

    // randomized run: outputs keyed by count of enabled edges
    begin
      int          en = 0;
      int          p1 = 0;
      int          p3 = 0;
      bit          ev1 = 1'b0, ev3 = 1'b0;
      logic [63:0] h0 = '0, h1 = '0, h2 = '0, h3 = '0;
      bit          f0 = 1'b0, f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
      bit          iv, sg;
      logic [24:0] ra;
      logic [17:0] rb;
      rec_t        r;
      recs.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
        iv  = ($urandom % 3) != 0;
        sg  = $urandom % 2;
        ra  = rand_a();
        rb  = rand_b();
        CEM = ($urandom % 4) != 0;
        drive(iv, sg, ra, rb);
        @(posedge CLK);
        if (CEM) begin
          en++;
          if (iv) begin
            r.k = en;
            model(sg, ra, rb, 0, 0, 0, 43, r.o0, r.v0);
            model(sg, ra, rb, 4, 1, 1, 16, r.o1, r.v1);
            model(sg, ra, rb, 4, 1, 0, 16, r.o2, r.v2);
            recs.push_back(r);
          end
          ev1 = 1'b0;
          if (p1 < recs.size() && recs[p1].k == en) begin
            ev1 = 1'b1;
            h0 = recs[p1].o0; f0 = recs[p1].v0;
            h1 = recs[p1].o1; f1 = recs[p1].v1;
            h2 = recs[p1].o2; f2 = recs[p1].v2;
            p1++;
          end
          ev3 = 1'b0;
          if (p3 < recs.size() && recs[p3].k + 2 == en) begin
            ev3 = 1'b1;
            h3 = recs[p3].o0; f3 = recs[p3].v0;
            p3++;
          end
        end
        @(negedge CLK);
        chk("rnd_vld0", 64'(if0.OUT_VALID), 64'(ev1));
        chk("rnd_out0", 64'(if0.MULT_OUT), h0);
        chk("rnd_ovf0", 64'(if0.OVF), 64'(f0));
        chk("rnd_vld1", 64'(if1.OUT_VALID), 64'(ev1));
        chk("rnd_out1", 64'(if1.MULT_OUT), h1);
        chk("rnd_ovf1", 64'(if1.OVF), 64'(f1));
        chk("rnd_vld2", 64'(if2.OUT_VALID), 64'(ev1));
        chk("rnd_out2", 64'(if2.MULT_OUT), h2);
        chk("rnd_ovf2", 64'(if2.OVF), 64'(f2));
        chk("rnd_vld3", 64'(if3.OUT_VALID), 64'(ev3));
        chk("rnd_out3", 64'(if3.MULT_OUT), h3);
        chk("rnd_ovf3", 64'(if3.OVF), 64'(f3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_pipe_stage.md
# mult_pipe_stage

Parametrised pipelined multiplier stage for the DSP slice: product of A_D and B, with per-sample signed/unsigned mode, optional scaling (right shift with round-half-up), saturate-or-wrap output fitting and valid tracking through a configurable register depth. It is the next-generation multiplier output register that feeds the post-adder/accumulator. A register enable replaces clock gating.

## Interface
- A_WIDTH, 25, width of A_D operand
- B_WIDTH, 18, width of B operand
- MREG, 1, pipeline registers between inputs and outputs (legal 0..4)
- SHIFT, 0, arithmetic/logical right shift applied to product (0..A_WIDTH+B_WIDTH-1)
- ROUND, 0, 1 = round half up before shift (ignored when SHIFT=0)
- SAT, 0, 1 = saturate to OUT_WIDTH, 0 = wrap (truncate MSBs)
- OUT_WIDTH, 43, output width (1..A_WIDTH+B_WIDTH+1)

- CLK  in  1  clock, rising edge
- RSTM_N  in  1  asynchronous active-low reset, clears all registers
- SRSTM  in  1  synchronous active-high flush of all stages
- CEM  in  1  pipeline enable; 0 = every stage holds
- IN_VALID  in  1  A_D/B/SIGNED_MODE valid this cycle
- SIGNED_MODE  in  1  1 = two's complement operands, 0 = unsigned
- A_D  in  A_WIDTH  operand A
- B  in  B_WIDTH  operand B
- OUT_VALID  out  1  MULT_OUT/OVF valid
- MULT_OUT  out  OUT_WIDTH  scaled, fitted product
- OVF  out  1  product did not fit OUT_WIDTH (set in both SAT modes)

## Operation
- Product formed at P = A_WIDTH+B_WIDTH+2 bits: operands sign-extended (SIGNED_MODE=1) or zero-extended (0).
- Scaling: if ROUND=1 and SHIFT>0, add 2^(SHIFT-1); then shift right SHIFT (arithmetic if signed, logical if unsigned). Carry from rounding kept in P bits.
- Fitting: range signed [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], unsigned [0, 2^OUT_WIDTH-1]. Out of range: OVF=1; SAT=1 clamps to nearest bound, SAT=0 keeps low OUT_WIDTH bits.
- Pipeline placement: MREG=1 post-processing ahead of the single register. MREG>=2 stage 1 registers raw product plus SIGNED_MODE; post-processing between stage 1 and 2; remaining stages delay. MREG=0 fully combinational, OUT_VALID=IN_VALID.
- Each stage carries a valid bit. Valid bits advance whenever CEM=1. Data/OVF of a stage load only when CEM=1 and incoming valid=1, otherwise hold (bubbles do not disturb held data).
- Priority: RSTM_N (async) > SRSTM > CEM.
- Reset values (RSTM_N low or SRSTM): all valid bits 0, all data 0, OVF 0; SRSTM acts even when CEM=0.

## Timing
- Latency MREG enabled cycles: sample accepted at edge k with CEM=1 appears at OUT_VALID after MREG edges where CEM=1.
- Throughput one sample per enabled cycle; no backpressure beyond CEM.
- CEM low: outputs and all stages frozen; OUT_VALID stays at its value.
- RSTM_N assertion mid-operation: outputs 0 immediately (asynchronously); in-flight samples lost. Deassertion is synchronised externally; first sample after release follows normal latency.
- SRSTM with IN_VALID=1 same cycle: sample dropped.

## Structure
- Package dsp_pkg: bound constants (MREG_MAX=4), the fit-range helper functions (signed/unsigned min/max for a width).
- Sub-module mult_postproc: combinational shift/round/fit/OVF, parametrised by P, SHIFT, ROUND, SAT, OUT_WIDTH, with SIGNED_MODE input.
- Top: product, stage registers generated over MREG, valid chain.

## Test plan
- Defaults, SIGNED_MODE=1, A_D=-3, B=5, IN_VALID pulse -> one cycle later OUT_VALID=1, MULT_OUT=-15, OVF=0.
- Defaults, A_D=25'h1FFFFFF, B=18'h3FFFF: unsigned -> 43'h7FFFDFC0001; signed -> 1; OVF=0.
- SHIFT=4, ROUND=1, SAT=1, OUT_WIDTH=16, signed: 24×1 -> 2; -24×1 -> -1; 4096×1024 -> 32767, OVF=1; unsigned 4096×1024 -> 65535, OVF=1.
- Same config SAT=0: signed 4096×1024 -> 16'h0000 (262144 wrapped), OVF=1.
- MREG=3, one valid sample, CEM low 2 cycles after acceptance -> OUT_VALID at 5th edge, output held while CEM=0, no duplicate valid.
- MREG=3, samples in flight: RSTM_N low -> OUT_VALID/MULT_OUT/OVF 0 immediately; SRSTM with CEM=0 -> all valid cleared next edge.
